// File: rtl/mux_sel_arbiter_pkg.sv
// mux_sel_arbiter_pkg: state encodings and helpers shared by mux-tree control blocks
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Smallest r with 2**r >= v; used for counter and select widths
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// mux_sel_arbiter_rr_pick: combinational round-robin winner search starting at PTR
module mux_sel_rr_pick #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic            o_valid,
    output logic [SELW-1:0] o_idx,
    output logic [N-1:0]    o_onehot
);

    // Scan offsets from the far end down so the offset closest to PTR wins
    always_comb begin
        int k;
        k        = 0;
        o_valid  = 1'b0;
        o_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(i_ptr) + i) % N;
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = SELW'(k);
            end
        end
        o_onehot = o_valid ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner of the mux-tree select lines with break-before-make gap
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int SELW     = 2,
    parameter int HOLD_MAX = 16,
    parameter int GAP_LEN  = 1
) (
    input  logic            CK,
    input  logic            CD,
    input  logic [N-1:0]    REQ,
    input  logic            DONE,
    output logic [N-1:0]    GNT,
    output logic [SELW-1:0] SEL,
    output logic            BUSY,
    output logic            TOUT
);

    localparam int CW = (clog2(HOLD_MAX) > 0) ? clog2(HOLD_MAX) : 1;

    arb_state_t      r_state;
    logic [SELW-1:0] r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_gap;
    logic [N-1:0]    r_gnt;
    logic [SELW-1:0] r_sel;
    logic            r_busy;
    logic            r_tout;

    logic            w_valid;
    logic [SELW-1:0] w_idx;
    logic [N-1:0]    w_onehot;
    logic            w_tmo;
    logic            w_rel;
    logic [SELW-1:0] w_ptr_nxt;

    mux_sel_rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .i_req    (REQ),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    // r_sel holds the owner index for the whole grant, so it names the owner's request line
    assign w_tmo     = r_cnt == CW'(HOLD_MAX - 1);
    assign w_rel     = DONE || !REQ[r_sel] || w_tmo;
    assign w_ptr_nxt = (r_sel == SELW'(N - 1)) ? '0 : r_sel + 1'b1;

    // Arbitration FSM with all outputs registered; SEL only changes on a new grant
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                IDLE: if (w_valid) begin
                    r_gnt   <= w_onehot;
                    r_sel   <= w_idx;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= GRANT;
                end
                GRANT: if (w_rel) begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_nxt;
                    r_tout  <= w_tmo && !DONE && REQ[r_sel];
                    r_gap   <= '0;
                    r_state <= (GAP_LEN > 0) ? GAP : IDLE;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                GAP: if (r_gap == 3'(GAP_LEN - 1)) r_state <= IDLE;
                     else r_gap <= r_gap + 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GNT  = r_gnt;
    assign SEL  = r_sel;
    assign BUSY = r_busy;
    assign TOUT = r_tout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed checks on N=4 plus a random N=3 invariant/fairness run
module tb_mux_sel_arbiter;

    logic       CK = 1'b0;
    logic       CD = 1'b1;
    logic [3:0] REQ = '0;
    logic       DONE = 1'b0;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       BUSY, TOUT;

    logic [2:0] REQ3 = '0;
    logic       DONE3 = 1'b0;
    logic [2:0] GNT3;
    logic [1:0] SEL3;
    logic       BUSY3, TOUT3;

    int n_tests = 0;
    int n_fail  = 0;
    int z;
    int w [3];

    always #5 CK = ~CK;

    mux_sel_arbiter #(.N(4), .SELW(2), .HOLD_MAX(16), .GAP_LEN(1)) u_dut (
        .CK(CK), .CD(CD), .REQ(REQ), .DONE(DONE),
        .GNT(GNT), .SEL(SEL), .BUSY(BUSY), .TOUT(TOUT)
    );

    mux_sel_arbiter #(.N(3), .SELW(2), .HOLD_MAX(16), .GAP_LEN(1)) u_dut3 (
        .CK(CK), .CD(CD), .REQ(REQ3), .DONE(DONE3),
        .GNT(GNT3), .SEL(SEL3), .BUSY(BUSY3), .TOUT(TOUT3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_grant(output int zc);
        zc = 0;
        while (GNT == 4'b0 && zc < 20) begin
            step();
            zc++;
        end
        chk("grant_timeout", 32'(zc < 20), 1);
    endtask

    initial begin
        step();
        step();
        CD = 1'b0;
        chk("rst_gnt",  GNT,  0);
        chk("rst_sel",  SEL,  0);
        chk("rst_busy", BUSY, 0);
        chk("rst_tout", TOUT, 0);

        // Asynchronous reset in the middle of a grant to source 2
        REQ = 4'b0100;
        step();
        chk("t1_gnt", GNT, 4'b0100);
        chk("t1_sel", SEL, 2);
        #2 CD = 1'b1;
        #1;
        chk("t1_async_gnt",  GNT,  0);
        chk("t1_async_sel",  SEL,  0);
        chk("t1_async_busy", BUSY, 0);
        #1 CD = 1'b0;
        REQ = 4'b0000;
        step();

        // All requesting, DONE after two grant cycles: 0,1,2,3,0 with 2 idle cycles between
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(z);
            if (k > 0) chk("t2_zero_cycles", z, 2);
            chk("t2_gnt",  GNT,  32'(1) << (k % 4));
            chk("t2_sel",  SEL,  k % 4);
            chk("t2_busy", BUSY, 1);
            step();
            chk("t2_hold", GNT, 32'(1) << (k % 4));
            DONE = 1'b1;
            step();
            DONE = 1'b0;
            chk("t2_rel_gnt",  GNT,  0);
            chk("t2_rel_tout", TOUT, 0);
            chk("t2_rel_sel",  SEL,  k % 4);
        end
        REQ = 4'b0000;
        step();
        step();

        // Timeout: source 0 holds 16 cycles, TOUT pulses, regrant after 2 idle cycles
        REQ = 4'b0001;
        wait_grant(z);
        chk("t3_gnt", GNT, 4'b0001);
        for (int k = 0; k < 15; k++) step();
        chk("t3_last_cycle", GNT, 4'b0001);
        chk("t3_no_tout_yet", TOUT, 0);
        step();
        chk("t3_rel_gnt", GNT, 0);
        chk("t3_tout", TOUT, 1);
        chk("t3_busy", BUSY, 0);
        step();
        chk("t3_tout_pulse", TOUT, 0);
        chk("t3_gap_gnt", GNT, 0);
        step();
        chk("t3_regrant", GNT, 4'b0001);

        // DONE coincides with the hold limit: normal release
        for (int k = 0; k < 15; k++) step();
        chk("t4_last_cycle", GNT, 4'b0001);
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        chk("t4_rel_gnt", GNT, 0);
        chk("t4_tout", TOUT, 0);
        REQ = 4'b0000;
        step();
        step();
        step();

        // Owner 2 drops REQ with 1010 pending; next goes to 3, SEL frozen in gap
        REQ = 4'b0100;
        wait_grant(z);
        chk("t5_gnt", GNT, 4'b0100);
        REQ = 4'b1110;
        step();
        chk("t5_hold", GNT, 4'b0100);
        REQ = 4'b1010;
        step();
        chk("t5_rel_gnt", GNT, 0);
        chk("t5_rel_sel", SEL, 2);
        step();
        chk("t5_gap_sel", SEL, 2);
        chk("t5_gap_gnt", GNT, 0);
        step();
        chk("t5_next_gnt", GNT, 4'b1000);
        chk("t5_next_sel", SEL, 3);
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        wait_grant(z);
        chk("t5_wrap_gnt", GNT, 4'b0010);
        chk("t5_wrap_sel", SEL, 1);
        REQ = 4'b0000;

        // Random N=3 run: invariants and bounded waiting
        for (int i = 0; i < 3; i++) w[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            chk("r_onehot", 32'($onehot0(GNT3)), 1);
            chk("r_sel_range", 32'(SEL3 < 2'd3), 1);
            chk("r_busy", BUSY3, 32'(|GNT3));
            if (BUSY3) chk("r_sel_idx", GNT3, 32'(3'(1) << SEL3));
            for (int i = 0; i < 3; i++) begin
                w[i] = (REQ3[i] && !GNT3[i]) ? w[i] + 1 : 0;
                if (w[i] > 3 * (16 + 1 + 1)) chk("r_fair", w[i], 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (!REQ3[i]) REQ3[i] = ($urandom_range(3) == 0);
                else if (GNT3[i] && $urandom_range(7) == 0) REQ3[i] = 1'b0;
            end
            DONE3 = ($urandom_range(7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
